alu_share_ctrl: RTL

Two-requester scheduler sharing the single combinational `alu` datapath between the execute stage (requester 0) and the debug/monitor port (requester 1). It arbitrates issue with fixed priority plus a starvation guard, drives the ALU operand/enable/carry inputs, registers the result in a one-entry output slot with valid/ready backpressure, and owns the architectural PSW flags (C, Z, N, V). Execute-stage results can be flushed.

---
 rtl/alu_share_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between execute (req 0) and debug (req 1).
// Ports: two valid/ready request ports, ALU drive/return, output slot, PSW.
module alu_share_ctrl #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [40:0] req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [40:0] req1_op,
  input  logic        flush,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [40:0] alu_enable,
  output logic        alu_carry_in,
  input  logic [15:0] alu_result,
  input  logic        alu_enable_psw_msk,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic        out_src,
  input  logic        psw_load,
  input  logic [3:0]  psw_wdata,
  output logic        psw_c,
  output logic        psw_z,
  output logic        psw_n,
  output logic        psw_v
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0]  wait_cnt;
  logic        slot_free;
  logic        elig0;
  logic        starved;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [40:0] sel_op;
  logic        is_add;
  logic        is_sub;
  logic        ci;
  logic [15:0] opb;
  logic [16:0] sum;
  logic        ovf;

  always_comb begin
    slot_free  = !out_valid | out_ready;
    elig0      = req0_valid & !flush;
    starved    = (wait_cnt == LIM);
    grant1     = req1_valid & (starved | !elig0);
    grant0     = elig0 & !grant1;
    req0_ready = slot_free & grant0;
    req1_ready = slot_free & grant1;
    accept     = req0_ready | req1_ready;
  end

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    sel_op = '0;
    unique case (1'b1)
      grant1: begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        sel_op = req1_op;
      end
      grant0: begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        sel_op = req0_op;
      end
      default: ;
    endcase
    alu_enable   = accept ? sel_op : '0;
    alu_carry_in = psw_c;
  end

  // Flag arithmetic is recomputed here so C/V never depend on ALU internals.
  always_comb begin
    is_add = sel_op[9] | sel_op[10];
    is_sub = sel_op[11] | sel_op[12] | sel_op[14];
    opb    = is_sub ? ~alu_b : alu_b;
    ci     = 1'b0;
    unique case (1'b1)
      sel_op[10] | sel_op[12]: ci = psw_c;
      sel_op[11] | sel_op[14]: ci = 1'b1;
      default:                 ci = 1'b0;
    endcase
    sum = {1'b0, alu_a} + {1'b0, opb} + {16'b0, ci};
    ovf = (alu_a[15] == opb[15]) & (sum[15] != alu_a[15]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!req1_valid | req1_ready) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_src    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_src    <= grant1;
    end else if (out_valid & out_ready) begin
      out_valid  <= 1'b0;
    end else if (flush & out_valid & !out_src) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psw_c <= 1'b0;
      psw_z <= 1'b0;
      psw_n <= 1'b0;
      psw_v <= 1'b0;
    end else if (psw_load) begin
      {psw_v, psw_n, psw_z, psw_c} <= psw_wdata;
    end else if (accept & alu_enable_psw_msk) begin
      psw_z <= (alu_result == 16'h0000);
      psw_n <= alu_result[15];
      if (is_add | is_sub) begin
        psw_c <= sum[16];
        psw_v <= ovf;
      end
    end
  end

endmodule
